// File: rtl/vga_frame_reader.sv
// VGA timing generator that reads an RGB444 frame buffer and upscales each stored pixel 2x2.
// Define VGA_TEST_PATTERN_EN to add test_pattern_i, which selects eight vertical colour bars.
module vga_frame_reader #(
   parameter int CLK_DIV    = 4,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SRC_WIDTH  = 320,
   parameter int SRC_HEIGHT = 240,
   parameter int ADDR_WIDTH = $clog2(SRC_WIDTH * SRC_HEIGHT),
   parameter int DATA_WIDTH = 12
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                  test_pattern_i,
`endif
   input  logic [DATA_WIDTH-1:0] pixel_data_i,
   output logic [ADDR_WIDTH-1:0] pixel_read_address_o,
   output logic [3:0]            vga_r_o,
   output logic [3:0]            vga_g_o,
   output logic [3:0]            vga_b_o,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic                  video_on_o,
   output logic                  frame_start_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [H_W-1:0]        H_LAST    = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0]        H_VIS     = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0]        HS_FIRST  = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0]        HS_LAST   = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [V_W-1:0]        V_LAST    = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0]        V_VIS     = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0]        VS_FIRST  = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0]        VS_LAST   = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(SRC_WIDTH);

   logic [DIV_W-1:0]      div_q, div_d;
   logic                  tick;
   logic [H_W-1:0]        h_q, h_d;
   logic [V_W-1:0]        v_q, v_d;
   logic [ADDR_WIDTH-1:0] col_q, col_d;
   logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  h_vis, v_vis, vis0, hs0, vs0;
   logic                  vis1_q, vis1_d, hs1_q, hs1_d, vs1_q, vs1_d;
   logic [11:0]           rgb_q, rgb_d;
   logic                  hs2_q, hs2_d, vs2_q, vs2_d, von2_q, von2_d;
   logic                  fs_q, fs_d;
   logic [11:0]           pix_rgb;

`ifdef VGA_TEST_PATTERN_EN
   logic                  tp1_q, tp1_d;
   logic [11:0]           bar1_q, bar1_d;

   // Bar index is h / (H_ACTIVE/8) found by comparison; the colour bits fall out of the index bits.
   function automatic logic [11:0] bar_colour(input logic [H_W-1:0] h);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (h >= H_W'(i * (H_ACTIVE / 8))) idx = 3'(i);
      end
      return {{4{~idx[1]}}, {4{~idx[2]}}, {4{~idx[0]}}};
   endfunction
`endif

   assign tick    = (div_q == DIV_LAST);
   assign h_vis   = (h_q < H_VIS);
   assign v_vis   = (v_q < V_VIS);
   assign vis0    = h_vis && v_vis;
   assign hs0     = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
   assign vs0     = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
   assign pix_rgb = pixel_data_i[11:0];

   // Stage 0 counters advance on tick; stage 1 registers address and syncs, stage 2 drives the pins.
   always_comb begin
      div_d       = tick ? '0 : div_q + DIV_W'(1);
      h_d         = h_q;
      v_d         = v_q;
      col_d       = col_q;
      line_base_d = line_base_q;
      addr_d      = addr_q;
      vis1_d      = vis1_q;
      hs1_d       = hs1_q;
      vs1_d       = vs1_q;
      rgb_d       = rgb_q;
      hs2_d       = hs2_q;
      vs2_d       = vs2_q;
      von2_d      = von2_q;
      fs_d        = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      tp1_d       = tp1_q;
      bar1_d      = bar1_q;
`endif
      if (tick) begin
         if (h_q == H_LAST) begin
            h_d   = '0;
            col_d = '0;
            if (v_q == V_LAST) begin
               v_d         = '0;
               line_base_d = '0;
            end else begin
               v_d = v_q + V_W'(1);
               if (v_vis && v_q[0]) line_base_d = line_base_q + LINE_STEP;
            end
         end else begin
            h_d = h_q + H_W'(1);
            if (h_vis && h_q[0]) col_d = col_q + ADDR_WIDTH'(1);
         end
         addr_d = vis0 ? line_base_q + col_q : '0;
         vis1_d = vis0;
         hs1_d  = hs0;
         vs1_d  = vs0;
`ifdef VGA_TEST_PATTERN_EN
         tp1_d  = test_pattern_i;
         bar1_d = bar_colour(h_q);
         rgb_d  = !vis1_q ? 12'h000 : (tp1_q ? bar1_q : pix_rgb);
`else
         rgb_d  = vis1_q ? pix_rgb : 12'h000;
`endif
         hs2_d  = hs1_q;
         vs2_d  = vs1_q;
         von2_d = vis1_q;
         fs_d   = (h_q == '0) && (v_q == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         div_q       <= '0;
         h_q         <= '0;
         v_q         <= '0;
         col_q       <= '0;
         line_base_q <= '0;
         addr_q      <= '0;
         vis1_q      <= 1'b0;
         hs1_q       <= 1'b1;
         vs1_q       <= 1'b1;
         rgb_q       <= '0;
         hs2_q       <= 1'b1;
         vs2_q       <= 1'b1;
         von2_q      <= 1'b0;
         fs_q        <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
         tp1_q       <= 1'b0;
         bar1_q      <= '0;
`endif
      end else begin
         div_q       <= div_d;
         h_q         <= h_d;
         v_q         <= v_d;
         col_q       <= col_d;
         line_base_q <= line_base_d;
         addr_q      <= addr_d;
         vis1_q      <= vis1_d;
         hs1_q       <= hs1_d;
         vs1_q       <= vs1_d;
         rgb_q       <= rgb_d;
         hs2_q       <= hs2_d;
         vs2_q       <= vs2_d;
         von2_q      <= von2_d;
         fs_q        <= fs_d;
`ifdef VGA_TEST_PATTERN_EN
         tp1_q       <= tp1_d;
         bar1_q      <= bar1_d;
`endif
      end
   end

   assign pixel_read_address_o = addr_q;
   assign vga_r_o              = rgb_q[11:8];
   assign vga_g_o              = rgb_q[7:4];
   assign vga_b_o              = rgb_q[3:0];
   assign hsync_o              = hs2_q;
   assign vsync_o              = vs2_q;
   assign video_on_o           = von2_q;
   assign frame_start_o        = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a shrunken 24x12 raster (16x8 visible, 8x4 source, CLK_DIV=2)
// so whole frames, a mid-frame reset and the optional colour bars fit in a short run.
module tb_vga_frame_reader;

   localparam int D     = 2;
   localparam int HT    = 24;
   localparam int VT    = 12;
   localparam int AW    = 5;
   localparam int FRAME = HT * VT * D;

   typedef struct {
      int h;
      int v;
      int addr;
      bit hs;
      bit vs;
      bit von;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset_i;
   logic [11:0]   pixData;
   logic [AW-1:0] addr;
   logic [3:0]    vgaR, vgaG, vgaB;
   logic          hsync, vsync, videoOn, frameStart;
`ifdef VGA_TEST_PATTERN_EN
   logic          testPattern;
`endif

   int   cyc;
   int   tests = 0;
   int   failed = 0;
   int   fsCount = 0;
   int   fsLast = -1;
   int   fsBase;
   vec_t vecs[17];

   always #5 clk = ~clk;

   vga_frame_reader #(
      .CLK_DIV(D), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SRC_WIDTH(8), .SRC_HEIGHT(4), .ADDR_WIDTH(AW), .DATA_WIDTH(12)
   ) dut (
      .clk_i(clk),
      .reset_i(reset_i),
`ifdef VGA_TEST_PATTERN_EN
      .test_pattern_i(testPattern),
`endif
      .pixel_data_i(pixData),
      .pixel_read_address_o(addr),
      .vga_r_o(vgaR),
      .vga_g_o(vgaG),
      .vga_b_o(vgaB),
      .hsync_o(hsync),
      .vsync_o(vsync),
      .video_on_o(videoOn),
      .frame_start_o(frameStart)
   );

   // Frame buffer contents are a fixed scramble of the address, returned one clock after the address.
   function automatic logic [11:0] fbWord(input int a);
      return 12'((a * 37 + 5) & 4095);
   endfunction

   always @(posedge clk) pixData <= fbWord(int'(addr));

   // Cycle index since the last clock edge that sampled reset.
   always @(posedge clk) begin
      if (reset_i) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (frameStart === 1'b1) begin
         fsCount++;
         fsLast = cyc;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: actual %0h, required %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic rst);
      reset_i = rst;
   endtask

   task automatic advanceTo(input int target);
      int guard;
      guard = 0;
      while (cyc < target && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != target) checkOutput("advance", cyc, target);
   endtask

   task automatic checkPins(input string tag, input logic [11:0] rgb, input bit hs, input bit vs, input bit on);
      checkOutput({tag, " rgb"}, {vgaR, vgaG, vgaB}, rgb);
      checkOutput({tag, " hsync"}, hsync, hs);
      checkOutput({tag, " vsync"}, vsync, vs);
      checkOutput({tag, " video_on"}, videoOn, on);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " addr"}, addr, 0);
      checkOutput({tag, " frame_start"}, frameStart, 0);
      checkPins(tag, 12'h000, 1'b1, 1'b1, 1'b0);
   endtask

   // Address is checked over its whole stage-1 hold, pins at the first cycle of stage 2.
   task automatic runTable();
      for (int i = 0; i < 17; i++) begin
         int    p;
         string tag;
         p   = vecs[i].v * HT + vecs[i].h;
         tag = $sformatf("v%0d h%0d", vecs[i].v, vecs[i].h);
         advanceTo((p + 1) * D);
         checkOutput({tag, " addr"}, addr, vecs[i].addr);
         advanceTo((p + 2) * D - 1);
         checkOutput({tag, " addr hold"}, addr, vecs[i].addr);
         advanceTo((p + 2) * D);
         checkPins(tag, vecs[i].von ? fbWord(vecs[i].addr) : 12'h000, vecs[i].hs, vecs[i].vs, vecs[i].von);
      end
   endtask

   initial begin
      logic [11:0] bars[8];
      bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

      //           h   v  addr hs vs von
      vecs[0]  = '{0,  0, 0,   1, 1, 1};
      vecs[1]  = '{1,  0, 0,   1, 1, 1};
      vecs[2]  = '{2,  0, 1,   1, 1, 1};
      vecs[3]  = '{5,  0, 2,   1, 1, 1};
      vecs[4]  = '{15, 0, 7,   1, 1, 1};
      vecs[5]  = '{16, 0, 0,   1, 1, 0};
      vecs[6]  = '{18, 0, 0,   0, 1, 0};
      vecs[7]  = '{20, 0, 0,   0, 1, 0};
      vecs[8]  = '{21, 0, 0,   1, 1, 0};
      vecs[9]  = '{3,  1, 1,   1, 1, 1};
      vecs[10] = '{0,  2, 8,   1, 1, 1};
      vecs[11] = '{5,  3, 10,  1, 1, 1};
      vecs[12] = '{15, 7, 31,  1, 1, 1};
      vecs[13] = '{0,  8, 0,   1, 1, 0};
      vecs[14] = '{4,  9, 0,   1, 0, 0};
      vecs[15] = '{23, 10, 0,  1, 0, 0};
      vecs[16] = '{0,  11, 0,  1, 1, 0};

`ifdef VGA_TEST_PATTERN_EN
      testPattern = 1'b0;
`endif
      applyStimulus(1'b1);
      repeat (3) @(negedge clk);
      fsBase = fsCount;
      checkResetState("reset");
      applyStimulus(1'b0);

      runTable();
      checkOutput("frame_start count frame 1", fsCount - fsBase, 1);
      checkOutput("frame_start cycle frame 1", fsLast, D);
      advanceTo(FRAME + D + 1);
      checkOutput("frame_start count frame 2", fsCount - fsBase, 2);
      checkOutput("frame_start cycle frame 2", fsLast, FRAME + D);

      // Second frame: reset while counters sit at v=5, h=7; pins then show v=5, h=5.
      advanceTo(FRAME + (5 * HT + 7) * D);
      checkPins("pre-reset v5 h5", fbWord(18), 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1);
      @(negedge clk);
      fsBase = fsCount;
      checkResetState("mid-frame reset");
      applyStimulus(1'b0);
      runTable();
      checkOutput("frame_start count after reset", fsCount - fsBase, 1);
      checkOutput("frame_start cycle after reset", fsLast, D);

`ifdef VGA_TEST_PATTERN_EN
      applyStimulus(1'b1);
      testPattern = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0);
      for (int h = 0; h < 16; h++) begin
         advanceTo((3 * HT + h + 2) * D);
         checkOutput($sformatf("bars v3 h%0d rgb", h), {vgaR, vgaG, vgaB}, bars[h / 2]);
         checkOutput($sformatf("bars v3 h%0d video_on", h), videoOn, 1);
      end
      advanceTo((3 * HT + 18 + 2) * D);
      checkOutput("bars v3 h18 hsync", hsync, 0);
      checkOutput("bars v3 h18 rgb", {vgaR, vgaG, vgaB}, 0);
      advanceTo((4 * HT + 5 + 1) * D);
      checkOutput("bars v4 h5 addr", addr, 18);
      testPattern = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
